mul_feeder: RTL and testbench

MUL_FEEDER -- requirements
Module: mul_feeder

---
 rtl/mul_feeder.sv | 165 ++++++++++++++++
 tb/tb_mul_feeder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_feeder.sv
// Operand feeder for a serial repeated-add multiplier: queues {a,b} pairs, streams them to the
// multiplier, waits for completion with a timeout, and presents each product to a ready/valid sink.
module mul_feeder #(
    parameter int W       = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 70000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         mul_start,
    output logic [W-1:0] mul_data_in,
    input  logic         mul_done,
    input  logic [W-1:0] mul_product,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_err,
    output logic         busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_LDA   = 3'd2;
    localparam logic [2:0] S_LDB   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;

    logic [2*W-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [2:0]     state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [W-1:0]   data_q, data_d;
    logic [W-1:0]   res_data_q, res_data_d;
    logic           res_err_q, res_err_d;
    logic [CW-1:0]  wcnt_q, wcnt_d;

    logic           fifo_full, fifo_empty, push, pop;
    logic [W-1:0]   head_a, head_b;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign push       = op_valid && !fifo_full;
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    assign {head_a, head_b} = mem_q[rd_ptr_q];

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {op_a, op_b};
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        data_d     = data_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        wcnt_d     = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    a_d = head_a;
                    b_d = head_b;
                    // A zero operand would never terminate the repeated-add loop, so answer directly.
                    if (head_a == '0 || head_b == '0) begin
                        res_data_d = '0;
                        res_err_d  = 1'b0;
                        state_d    = S_OUT;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                data_d  = a_q;
                state_d = S_LDA;
            end
            S_LDA: begin
                data_d  = b_q;
                state_d = S_LDB;
            end
            S_LDB: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + 1'b1;
                if (mul_done) begin
                    res_data_d = mul_product;
                    res_err_d  = 1'b0;
                    state_d    = S_OUT;
                end else if (wcnt_q == LAST_WAIT) begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            data_q     <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            wcnt_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            data_q     <= data_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
            wcnt_q     <= wcnt_d;
        end
    end

    assign op_ready    = !fifo_full;
    assign mul_start   = (state_q == S_START);
    assign mul_data_in = data_q;
    assign res_valid   = (state_q == S_OUT);
    assign res_data    = res_data_q;
    assign res_err     = res_err_q;
    assign busy        = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mul_feeder.sv
// Directed bench for mul_feeder with a small serial-multiplier model; TIMEOUT is shortened to 20.
module tb_mul_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        mul_start;
    logic [15:0] mul_data_in;
    logic        mul_done = 1'b0;
    logic [15:0] mul_product = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int startCount = 0;
    int hsCount = 0;

    logic        mulEnable = 1'b1;
    int          mulLatency = 2;
    int          mPhase = 0;
    int          mCnt = 0;
    logic [15:0] mA = '0;
    logic [15:0] mB = '0;

    mul_feeder #(.W(16), .DEPTH(4), .TIMEOUT(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mul_start(mul_start), .mul_data_in(mul_data_in),
        .mul_done(mul_done), .mul_product(mul_product),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier model: start, then a and b on the bus in the next two cycles, done after a short delay.
    always @(posedge clk) begin
        if (mul_start) begin
            mPhase   <= 1;
            mul_done <= 1'b0;
        end else begin
            case (mPhase)
                1: begin mA <= mul_data_in; mPhase <= 2; end
                2: begin mB <= mul_data_in; mCnt <= 0; mPhase <= 3; end
                3: begin
                    if (mCnt >= mulLatency) begin
                        mul_done    <= mulEnable;
                        mul_product <= mA * mB;
                        mPhase      <= 0;
                    end else begin
                        mCnt <= mCnt + 1;
                    end
                end
                default: ;
            endcase
        end
        if (mul_start) startCount <= startCount + 1;
        if (res_valid && res_ready) hsCount <= hsCount + 1;
    end

    task automatic test_reset;
        @(negedge clk);
        checks++; if (op_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_op_ready: got %b expected 1", op_ready); end
        checks++; if (mul_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_mul_start: got %b expected 0", mul_start); end
        checks++; if (mul_data_in !== 16'd0) begin errors++; $display("[TB] FAIL reset_mul_data_in: got %0d expected 0", mul_data_in); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid: got %b expected 0", res_valid); end
        checks++; if (res_data !== 16'd0) begin errors++; $display("[TB] FAIL reset_res_data: got %0d expected 0", res_data); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_err: got %b expected 0", res_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int s = -100;
        int startCycles = 0;
        int hs0;
        logic [15:0] dA = '0;
        logic [15:0] dB = '0;
        hs0 = hsCount;
        op_valid = 1'b1; op_a = 16'd15; op_b = 16'd9;
        @(negedge clk);
        op_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL first_push_after_reset: busy got %b expected 1", busy); end
        for (int i = 0; i < 60 && !res_valid; i++) begin
            @(negedge clk);
            if (mul_start) begin startCycles++; s = i; end
            if (i == s + 1) dA = mul_data_in;
            if (i == s + 2) dB = mul_data_in;
        end
        checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_wait_valid: res_valid got %b expected 1 within 60 cycles", res_valid); end
        checks++; if (startCycles !== 1) begin errors++; $display("[TB] FAIL basic_start_pulse: got %0d cycles expected 1", startCycles); end
        checks++; if (dA !== 16'd15) begin errors++; $display("[TB] FAIL basic_bus_a: got %0d expected 15", dA); end
        checks++; if (dB !== 16'd9) begin errors++; $display("[TB] FAIL basic_bus_b: got %0d expected 9", dB); end
        checks++; if (res_data !== 16'd135) begin errors++; $display("[TB] FAIL basic_data: got %0d expected 135", res_data); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("[TB] FAIL basic_err: got %b expected 0", res_err); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_drop: got %b expected 0", res_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle: busy got %b expected 0", busy); end
        checks++; if (hsCount - hs0 !== 1) begin errors++; $display("[TB] FAIL basic_handshakes: got %0d expected 1", hsCount - hs0); end
    endtask

    task automatic test_bypass;
        logic [15:0] va [2] = '{16'd0, 16'd5};
        logic [15:0] vb [2] = '{16'd7, 16'd0};
        int st0;
        st0 = startCount;
        for (int k = 0; k < 2; k++) begin
            op_valid = 1'b1; op_a = va[k]; op_b = vb[k];
            @(negedge clk);
            op_valid = 1'b0;
            // Pair sits at the FIFO head this cycle and is popped on the next edge.
            checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL bypass%0d_early: res_valid got %b expected 0", k, res_valid); end
            @(negedge clk);
            checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL bypass%0d_valid: got %b expected 1", k, res_valid); end
            checks++; if (res_data !== 16'd0) begin errors++; $display("[TB] FAIL bypass%0d_data: got %0d expected 0", k, res_data); end
            checks++; if (res_err !== 1'b0) begin errors++; $display("[TB] FAIL bypass%0d_err: got %b expected 0", k, res_err); end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
        repeat (2) @(negedge clk);
        checks++; if (startCount !== st0) begin errors++; $display("[TB] FAIL bypass_no_start: got %0d starts expected 0", startCount - st0); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp [5] = '{16'd6, 16'd20, 16'd42, 16'd72, 16'd110};
        logic [15:0] got [5];
        int n = 0;
        for (int k = 0; k < 5; k++) begin
            checks++; if (op_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready%0d: got %b expected 1", k, op_ready); end
            op_valid = 1'b1; op_a = 16'(2 + 2 * k); op_b = 16'(3 + 2 * k);
            @(negedge clk);
        end
        checks++; if (op_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_full: op_ready got %b expected 0", op_ready); end
        op_valid = 1'b0;
        repeat (15) @(negedge clk);
        checks++; if (res_valid !== 1'b1 || res_data !== 16'd6) begin errors++; $display("[TB] FAIL b2b_held: valid %b data %0d expected 1 and 6", res_valid, res_data); end
        res_ready = 1'b1;
        for (int i = 0; i < 150 && n < 5; i++) begin
            if (res_valid) begin got[n] = res_data; n++; end
            @(negedge clk);
        end
        res_ready = 1'b0;
        checks++; if (n !== 5) begin errors++; $display("[TB] FAIL b2b_count: got %0d results expected 5", n); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (k < n && got[k] !== exp[k]) begin errors++; $display("[TB] FAIL b2b_result%0d: got %0d expected %0d", k, got[k], exp[k]); end
        end
        repeat (3) @(negedge clk);
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drained: valid %b busy %b expected 0 0", res_valid, busy); end
    endtask

    task automatic test_timeout;
        int i;
        mulEnable = 1'b0;
        op_valid = 1'b1; op_a = 16'd3; op_b = 16'd4;
        @(negedge clk);
        op_valid = 1'b0;
        for (i = 0; i < 20 && !mul_start; i++) @(negedge clk);
        checks++; if (mul_start !== 1'b1) begin errors++; $display("[TB] FAIL timeout_start: mul_start got %b expected 1", mul_start); end
        // START, LDA, LDB, then 20 WAIT cycles before S_OUT.
        repeat (22) @(negedge clk);
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early: res_valid got %b expected 0", res_valid); end
        @(negedge clk);
        checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL timeout_valid: got %b expected 1", res_valid); end
        checks++; if (res_err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err: got %b expected 1", res_err); end
        checks++; if (res_data !== 16'd0) begin errors++; $display("[TB] FAIL timeout_data: got %0d expected 0", res_data); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        mulEnable = 1'b1;
    endtask

    task automatic test_hold;
        logic [15:0] exp [5] = '{16'd42, 16'd2, 16'd4, 16'd6, 16'd8};
        logic [15:0] got [5];
        int n = 0;
        int accepted = 0;
        op_valid = 1'b1; op_a = 16'd7; op_b = 16'd6;
        @(negedge clk);
        op_valid = 1'b0;
        for (int i = 0; i < 40 && !res_valid; i++) @(negedge clk);
        checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_wait_valid: got %b expected 1", res_valid); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (res_data !== 16'd42 || res_err !== 1'b0) begin errors++; $display("[TB] FAIL hold_stable%0d: data %0d err %b expected 42 0", i, res_data, res_err); end
            op_valid = 1'b1; op_a = 16'(accepted + 1); op_b = 16'd2;
            if (op_ready) accepted++;
            @(negedge clk);
        end
        op_valid = 1'b0;
        checks++; if (accepted !== 4) begin errors++; $display("[TB] FAIL hold_accepted: got %0d expected 4", accepted); end
        checks++; if (op_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_full: op_ready got %b expected 0", op_ready); end
        res_ready = 1'b1;
        for (int i = 0; i < 150 && n < 5; i++) begin
            if (res_valid) begin got[n] = res_data; n++; end
            @(negedge clk);
        end
        res_ready = 1'b0;
        checks++; if (n !== 5) begin errors++; $display("[TB] FAIL hold_count: got %0d results expected 5", n); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (k < n && got[k] !== exp[k]) begin errors++; $display("[TB] FAIL hold_result%0d: got %0d expected %0d", k, got[k], exp[k]); end
        end
    endtask

    task automatic test_reset_mid;
        logic sawValid = 1'b0;
        int st0;
        mulEnable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            op_valid = 1'b1; op_a = 16'(3 + k); op_b = 16'(3 + k);
            @(negedge clk);
        end
        op_valid = 1'b0;
        for (int i = 0; i < 20 && !mul_start; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_op_ready: got %b expected 1", op_ready); end
        checks++; if (mul_start !== 1'b0) begin errors++; $display("[TB] FAIL midreset_mul_start: got %b expected 0", mul_start); end
        checks++; if (mul_data_in !== 16'd0) begin errors++; $display("[TB] FAIL midreset_mul_data_in: got %0d expected 0", mul_data_in); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_res_valid: got %b expected 0", res_valid); end
        checks++; if (res_data !== 16'd0) begin errors++; $display("[TB] FAIL midreset_res_data: got %0d expected 0", res_data); end
        checks++; if (res_err !== 1'b0) begin errors++; $display("[TB] FAIL midreset_res_err: got %b expected 0", res_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mulEnable = 1'b1;
        st0 = startCount;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (res_valid) sawValid = 1'b1;
        end
        checks++; if (sawValid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_no_result: res_valid seen %b expected 0", sawValid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_idle: busy got %b expected 0", busy); end
        checks++; if (startCount !== st0) begin errors++; $display("[TB] FAIL midreset_no_start: got %0d starts expected 0", startCount - st0); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_bypass;
        test_back_to_back;
        test_timeout;
        test_hold;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
